// File: rtl/i2c_target_pkg.sv
// Shared state encoding, byte length and ACK/NACK line levels for the I2C target responder.
package i2c_target_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StReg,
      StRegAck,
      StData,
      StDataAck,
      StIgnore
   } i2c_state_e;

   localparam int unsigned bitLength = 8;

   localparam logic Ack  = 1'b0;
   localparam logic Nack = 1'b1;

   // Address byte is ours only when it carries our 7-bit address and the write flag.
   function automatic logic addr_is_write(input logic [7:0] addr_byte, input logic [6:0] own);
      return (addr_byte[7:1] == own) && (addr_byte[0] == 1'b0);
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises scl/sda into refClock and emits single-cycle scl edge and START/STOP pulses.
module i2c_line_sync (
   input  logic refClock,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic sclRise,
   output logic sclFall,
   output logic startDet,
   output logic stopDet,
   output logic sdaLevel
);

   // [0] first sync flop, [1] synchronised value, [2] previous synchronised value
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   always_ff @(posedge refClock or posedge reset) begin
      if (reset) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl};
         sda_q <= {sda_q[1:0], sda};
      end
   end

   assign sclRise  = scl_q[1] & ~scl_q[2];
   assign sclFall  = ~scl_q[1] & scl_q[2];
   assign startDet = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stopDet  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
   assign sdaLevel = sda_q[1];

endmodule

// File: rtl/i2c_target_responder.sv
// I2C write-only target: address byte, register byte, then data byte(s), each ACKed on sda.
// Define I2C_TARGET_AUTOINC_EN to accept further data bytes with an auto-incremented regAddr.
module i2c_target_responder
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] slaveAddress = 7'h39
) (
   input  logic       refClock,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] regAddr,
   output logic [7:0] regData,
   output logic       writeStrobe,
   output logic       busy
);

   localparam logic [3:0] LastBit = 4'(bitLength);

   i2c_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] reg_addr_q, reg_addr_d;
   logic [7:0] reg_data_q, reg_data_d;
   logic       strobe_q, strobe_d;
   logic       busy_q, busy_d;

   logic scl_rise, scl_fall, start_det, stop_det, sda_level;
   logic ack_level, sda_oe;

   i2c_line_sync u_line_sync (
      .refClock (refClock),
      .reset    (reset),
      .scl      (scl),
      .sda      (sda),
      .sclRise  (scl_rise),
      .sclFall  (scl_fall),
      .startDet (start_det),
      .stopDet  (stop_det),
      .sdaLevel (sda_level)
   );

   always_ff @(posedge refClock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         shift_q    <= '0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         strobe_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         strobe_q   <= strobe_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      reg_addr_d = reg_addr_q;
      reg_data_d = reg_data_q;
      strobe_d   = 1'b0;
      busy_d     = busy_q;

      if (stop_det) begin
         state_d = StIdle;
         cnt_d   = '0;
         busy_d  = 1'b0;
      end else if (start_det) begin
         // Repeated START lands here too; busy is left as it was until the address decides.
         state_d = StAddr;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StAddr, StReg, StData: begin
               if (scl_rise && (cnt_q != LastBit)) begin
                  shift_d = {shift_q[6:0], sda_level};
                  cnt_d   = cnt_q + 4'd1;
               end else if (scl_fall && (cnt_q == LastBit)) begin
                  cnt_d = '0;
                  if (state_q == StAddr) begin
                     if (addr_is_write(shift_q, slaveAddress)) begin
                        state_d = StAddrAck;
                        busy_d  = 1'b1;
                     end else begin
                        state_d = StIgnore;
                        busy_d  = 1'b0;
                     end
                  end else if (state_q == StReg) begin
                     reg_addr_d = shift_q;
                     state_d    = StRegAck;
                  end else begin
                     reg_data_d = shift_q;
                     strobe_d   = 1'b1;
                     state_d    = StDataAck;
                  end
               end
            end
            StAddrAck: if (scl_fall) state_d = StReg;
            StRegAck:  if (scl_fall) state_d = StData;
            StDataAck: begin
               if (scl_fall) begin
`ifdef I2C_TARGET_AUTOINC_EN
                  state_d    = StData;
                  reg_addr_d = reg_addr_q + 8'd1;
`else
                  state_d = StIgnore;
                  busy_d  = 1'b0;
`endif
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      ack_level = Nack;
      if (state_q inside {StAddrAck, StRegAck, StDataAck}) begin
         ack_level = Ack;
      end
      sda_oe = (ack_level == Ack) && !reset;
   end

   assign sda         = sda_oe ? 1'b0 : 1'bz;
   assign regAddr     = reg_addr_q;
   assign regData     = reg_data_q;
   assign writeStrobe = strobe_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: directed vector table, reset corners and randomised transfers.
module tb_i2c_target_responder;

   localparam int Q = 8;
   localparam logic [6:0] Slave = 7'h39;
`ifdef I2C_TARGET_AUTOINC_EN
   localparam bit AutoInc = 1'b1;
`else
   localparam bit AutoInc = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       scl;
   logic       sda_low;
   wire        sda;
   logic [7:0] regAddr;
   logic [7:0] regData;
   logic       writeStrobe;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [15:0] str_q[$];
   int          drove_cnt = 0;

   assign sda = sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_target_responder #(
      .slaveAddress (Slave)
   ) dut (
      .refClock    (clk),
      .reset       (reset),
      .scl         (scl),
      .sda         (sda),
      .regAddr     (regAddr),
      .regData     (regData),
      .writeStrobe (writeStrobe),
      .busy        (busy)
   );

   always @(negedge clk) begin
      if (writeStrobe === 1'b1) str_q.push_back({regAddr, regData});
      if (!sda_low && sda === 1'b0) drove_cnt++;
   end

   typedef struct {
      logic [4:0][7:0]  b;
      int               n;
      int               rs_at;
      logic [4:0]       exp_ack;
      int               exp_ns;
      logic [3:0][15:0] exp_str;
      logic             busy_addr;
      logic             busy_pre;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic wt(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put_bit(input logic b);
      wt(Q / 2); sda_low = ~b;
      wt(Q / 2); scl = 1'b1;
      wt(Q);     scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(b[i]);
      wt(Q / 2); sda_low = 1'b0;
      wt(Q / 2); scl = 1'b1;
      wt(Q / 2); ack = (sda === 1'b0);
      wt(Q / 2); scl = 1'b0;
   endtask

   task automatic bus_start();
      wt(Q / 2); sda_low = 1'b0;
      wt(Q / 2); scl = 1'b1;
      wt(Q);     sda_low = 1'b1;
      wt(Q);     scl = 1'b0;
   endtask

   task automatic bus_stop();
      wt(Q / 2); sda_low = 1'b1;
      wt(Q / 2); scl = 1'b1;
      wt(Q);     sda_low = 1'b0;
      wt(Q);
   endtask

   // Reference: ACK pattern and strobes follow from address match and byte position alone.
   function automatic vec_t model(input logic [4:0][7:0] b, input int n);
      vec_t       v;
      logic       ok;
      logic [7:0] a;
      v.b = b; v.n = n; v.rs_at = -1;
      v.exp_ack = '0; v.exp_ns = 0; v.exp_str = '0;
      ok = (b[0] == {Slave, 1'b0});
      v.busy_addr = ok;
      v.busy_pre  = ok && (n < 3 || AutoInc);
      if (ok) begin
         v.exp_ack[0] = 1'b1;
         if (n > 1) v.exp_ack[1] = 1'b1;
         for (int k = 2; k < n; k++) begin
            if (k == 2 || AutoInc) begin
               a = b[1] + 8'(k - 2);
               v.exp_ack[k] = 1'b1;
               v.exp_str[v.exp_ns] = {a, b[k]};
               v.exp_ns++;
            end
         end
      end
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int         sb, db, ns;
      logic [4:0] acks;
      logic       ab, busy_a, busy_p;
      sb = str_q.size(); db = drove_cnt; acks = '0; busy_a = 1'b0;
      bus_start();
      for (int k = 0; k < v.n; k++) begin
         if (k == v.rs_at) bus_start();
         send_byte(v.b[k], ab);
         acks[k] = ab;
         if (k == 0) busy_a = busy;
      end
      wt(5); busy_p = busy;
      bus_stop();
      chk($sformatf("%s ack pattern", tag), 32'(acks), 32'(v.exp_ack));
      chk($sformatf("%s busy after addr", tag), 32'(busy_a), 32'(v.busy_addr));
      chk($sformatf("%s busy before stop", tag), 32'(busy_p), 32'(v.busy_pre));
      chk($sformatf("%s busy after stop", tag), 32'(busy), 32'd0);
      chk($sformatf("%s sda driven", tag), 32'(drove_cnt != db), 32'(v.exp_ack != '0));
      ns = str_q.size() - sb;
      chk($sformatf("%s strobe count", tag), 32'(ns), 32'(v.exp_ns));
      for (int i = 0; i < ns && i < v.exp_ns; i++) begin
         chk($sformatf("%s strobe%0d addr/data", tag, i), 32'(str_q[sb + i]),
             32'(v.exp_str[i]));
      end
   endtask

   initial begin
      logic [4:0][7:0] rb;
      logic            ab;
      int              sb, db;

      vecs[0] = '{40'h0000104172, 3, -1, 5'b00111, 1, 64'h0000_0000_0000_4110, 1'b1, AutoInc};
      vecs[1] = '{40'h0000104174, 3, -1, 5'b00000, 0, 64'h0, 1'b0, 1'b0};
      vecs[2] = '{40'h0000004173, 2, -1, 5'b00000, 0, 64'h0, 1'b0, 1'b0};
      vecs[3] = '{40'h00BBAAFF72, 4, -1, AutoInc ? 5'b01111 : 5'b00111, AutoInc ? 2 : 1,
                  64'h0000_0000_00BB_FFAA, 1'b1, AutoInc};
      vecs[4] = '{40'h6605724172, 5, 2, 5'b11111, 1, 64'h0000_0000_0000_0566, 1'b1, AutoInc};

      reset = 1'b1; scl = 1'b1; sda_low = 1'b0;
      wt(5);
      chk("reset regAddr", 32'(regAddr), 32'h0);
      chk("reset regData", 32'(regData), 32'h0);
      chk("reset writeStrobe", 32'(writeStrobe), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset sda released", 32'(sda === 1'b1), 32'h1);
      reset = 1'b0;
      wt(5);

      for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

      // Reset while the address ACK is being driven.
      bus_start();
      for (int i = 7; i >= 0; i--) put_bit(vecs[0].b[0][i]);
      wt(Q / 2); sda_low = 1'b0;
      wt(Q / 2); scl = 1'b1;
      wt(Q / 2);
      chk("midack sda low", 32'(sda === 1'b0), 32'h1);
      chk("midack busy", 32'(busy), 32'h1);
      #3 reset = 1'b1;
      #2;
      chk("midack rst sda released", 32'(sda === 1'b1), 32'h1);
      chk("midack rst busy", 32'(busy), 32'h0);
      chk("midack rst regAddr", 32'(regAddr), 32'h0);
      chk("midack rst regData", 32'(regData), 32'h0);
      chk("midack rst writeStrobe", 32'(writeStrobe), 32'h0);
      wt(3); reset = 1'b0;
      wt(Q / 2); scl = 1'b0;
      sb = str_q.size(); db = drove_cnt;
      send_byte(8'h72, ab);
      chk("post-reset no START ack", 32'(ab), 32'h0);
      bus_stop();
      chk("post-reset strobes", 32'(str_q.size() - sb), 32'h0);
      chk("post-reset sda driven", 32'(drove_cnt != db), 32'h0);

      for (int t = 0; t < 20; t++) begin
         int n;
         n = $urandom_range(1, 5);
         for (int k = 0; k < 5; k++) rb[k] = 8'($urandom);
         if ($urandom_range(0, 3) != 0) rb[0] = 8'h72;
         run_vec(model(rb, n), $sformatf("rnd%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
